// File: rtl/instr_exec.sv
// Mode-1 decode/execute sequencer: 8-bit accumulator, single-cycle ALU ops,
// shift-add MUL over the operand bits, and a one-cycle PC advance strobe.
module instr_exec #(
   parameter int DATA_W = 8,
   parameter int OPND_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ena,
   input  logic [7:0]        instr_in,
   input  logic              resume,
   output logic              pc_ena,
   output logic [DATA_W-1:0] acc_out,
   output logic              flag_zero,
   output logic              flag_carry,
   output logic              busy,
   output logic              halted,
   output logic [2:0]        state_out,
   output logic [7:0]        ir_out
);

   localparam int CNT_W  = $clog2(OPND_W);
   localparam int PROD_W = DATA_W + OPND_W;

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_EXEC  = 3'd1,
      S_MULT  = 3'd2,
      S_WB    = 3'd3,
      S_HALT  = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [7:0]          ir_q, ir_d;
   logic                zero_q, zero_d;
   logic                carry_q, carry_d;
   logic [DATA_W-1:0]   mcand_q, mcand_d;
   logic [OPND_W-1:0]   mplier_q, mplier_d;
   logic [PROD_W-1:0]   prod_q, prod_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [DATA_W-1:0]   op_ext;
   logic [DATA_W:0]     sum, diff;
   logic [PROD_W-1:0]   part, prod_nx;
   logic [DATA_W-1:0]   res;
   logic                wr;

   assign op_ext  = {{(DATA_W-OPND_W){1'b0}}, ir_q[OPND_W-1:0]};
   assign sum     = {1'b0, acc_q} + {1'b0, op_ext};
   assign diff    = {1'b0, acc_q} - {1'b0, op_ext};
   assign part    = mplier_q[cnt_q] ? (PROD_W'(mcand_q) << cnt_q) : '0;
   assign prod_nx = prod_q + part;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      ir_d     = ir_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      res      = acc_q;
      wr       = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            ir_d    = instr_in;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_WB;
            wr      = 1'b1;
            carry_d = 1'b0;
            unique case (ir_q[7:5])
               3'b000: begin
                  res     = sum[DATA_W-1:0];
                  carry_d = sum[DATA_W];
               end
               3'b001: begin
                  res     = diff[DATA_W-1:0];
                  carry_d = diff[DATA_W];
               end
               3'b010: begin
                  wr       = 1'b0;
                  carry_d  = carry_q;
                  mcand_d  = acc_q;
                  mplier_d = ir_q[OPND_W-1:0];
                  prod_d   = '0;
                  cnt_d    = '0;
                  state_d  = S_MULT;
               end
               3'b011: res = acc_q & op_ext;
               3'b100: res = acc_q | op_ext;
               3'b101: res = acc_q ^ op_ext;
               3'b110: res = op_ext;
               3'b111: begin
                  wr      = 1'b0;
                  carry_d = carry_q;
                  state_d = S_HALT;
               end
            endcase
            if (wr) begin
               acc_d  = res;
               zero_d = (res == '0);
            end
         end
         S_MULT: begin
            prod_d = prod_nx;
            cnt_d  = cnt_q + 1'b1;
            // Last multiplier bit: commit product and leave the loop
            if (cnt_q == CNT_W'(OPND_W-1)) begin
               acc_d   = prod_nx[DATA_W-1:0];
               carry_d = |prod_nx[PROD_W-1:DATA_W];
               zero_d  = (prod_nx[DATA_W-1:0] == '0);
               state_d = S_WB;
            end
         end
         S_WB:   state_d = S_FETCH;
         S_HALT: if (resume) state_d = S_WB;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_FETCH;
         acc_q    <= '0;
         ir_q     <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
      end else if (ena) begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         ir_q     <= ir_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
      end
   end

   assign pc_ena     = ena & (state_q == S_WB);
   assign acc_out    = acc_q;
   assign flag_zero  = zero_q;
   assign flag_carry = carry_q;
   assign busy       = (state_q != S_FETCH);
   assign halted     = (state_q == S_HALT);
   assign state_out  = state_q;
   assign ir_out     = ir_q;

endmodule

// File: tb/tb_instr_exec.sv
// Directed bench for instr_exec with a small PC/ROM model feeding instr_in.
module tb_instr_exec;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       ena = 1'b1;
   logic       resume = 1'b0;
   logic [7:0] instr_in;
   logic       pc_ena;
   logic [7:0] acc_out;
   logic       flag_zero, flag_carry, busy, halted;
   logic [2:0] state_out;
   logic [7:0] ir_out;

   logic [7:0] prog [16];
   logic [3:0] pc;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int dbl = 0;
   int bad;
   int n;
   logic prev_pe = 1'b0;

   always #5 clock = ~clock;

   instr_exec dut (
      .clock(clock), .reset(reset), .ena(ena), .instr_in(instr_in),
      .resume(resume), .pc_ena(pc_ena), .acc_out(acc_out),
      .flag_zero(flag_zero), .flag_carry(flag_carry), .busy(busy),
      .halted(halted), .state_out(state_out), .ir_out(ir_out)
   );

   always @(posedge clock or negedge reset)
      if (!reset) pc <= 4'd0;
      else if (pc_ena) pc <= pc + 4'd1;

   assign instr_in = prog[pc];

   always @(negedge clock) begin
      if (pc_ena && prev_pe) dbl = dbl + 1;
      prev_pe = pc_ena;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         failures = failures + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
      cyc = cyc + 1;
   endtask

   task automatic next_wb(input string tag);
      int k;
      k = 0;
      do begin
         step();
         k = k + 1;
      end while (!pc_ena && k < 40);
      if (!pc_ena) chk({tag, "_timeout"}, 32'(pc_ena), 32'd1);
   endtask

   task automatic load(input logic [7:0] p0, input logic [7:0] p1,
                       input logic [7:0] p2, input logic [7:0] p3);
      for (int i = 0; i < 16; i++) prog[i] = 8'h00;
      prog[0] = p0; prog[1] = p1; prog[2] = p2; prog[3] = p3;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      cyc = 0;
   endtask

   initial begin
      // Reset state
      load(8'h03, 8'h22, 8'h45, 8'h00);
      for (int i = 4; i < 8; i++) prog[i] = prog[i-4];
      repeat (3) @(negedge clock);
      chk("rst_acc", 32'(acc_out), 32'h0);
      chk("rst_state", 32'(state_out), 32'h0);
      chk("rst_outs", {pc_ena, flag_zero, flag_carry, busy, halted},
          32'h0);
      chk("rst_ir", 32'(ir_out), 32'h0);

      // Program loop: ADD 3, SUB 2, MUL 5, NOP, twice
      do_reset();
      next_wb("l0"); chk("l0_cyc", cyc, 2);  chk("l0_acc", acc_out, 3);
      next_wb("l1"); chk("l1_cyc", cyc, 5);  chk("l1_acc", acc_out, 1);
      next_wb("l2"); chk("l2_cyc", cyc, 13); chk("l2_acc", acc_out, 5);
      next_wb("l3"); chk("l3_cyc", cyc, 16); chk("l3_acc", acc_out, 5);
      next_wb("l4"); chk("l4_acc", acc_out, 8);
      next_wb("l5"); chk("l5_acc", acc_out, 6);
      next_wb("l6"); chk("l6_cyc", cyc, 30); chk("l6_acc", acc_out, 30);
      next_wb("l7"); chk("l7_cyc", cyc, 33); chk("l7_acc", acc_out, 30);

      // Async reset in the 3rd MULT cycle
      load(8'hC3, 8'h45, 8'h00, 8'h00);
      do_reset();
      next_wb("ra"); chk("ra_acc", acc_out, 3);
      repeat (5) step();
      chk("ra_mult", 32'(state_out), 32'd2);
      #1 reset = 1'b0;
      #1;
      chk("ra_acc0", 32'(acc_out), 32'h0);
      chk("ra_st0", 32'(state_out), 32'h0);
      chk("ra_outs0", {pc_ena, flag_zero, flag_carry, busy}, 32'h0);
      do_reset();
      step();
      chk("ra_exec", 32'(state_out), 32'd1);
      next_wb("rb"); chk("rb_cyc", cyc, 2); chk("rb_acc", acc_out, 3);

      // SUB borrow then AND 0
      load(8'hC2, 8'h23, 8'h60, 8'h00);
      do_reset();
      next_wb("s0"); chk("s0_acc", acc_out, 2);
      next_wb("s1"); chk("s1_acc", acc_out, 8'hFF);
      chk("s1_flags", {flag_carry, flag_zero}, 2'b10);
      next_wb("s2"); chk("s2_acc", acc_out, 0);
      chk("s2_flags", {flag_carry, flag_zero}, 2'b01);

      // MUL overflow 31*31
      load(8'hDF, 8'h5F, 8'h00, 8'h00);
      do_reset();
      next_wb("m0"); chk("m0_acc", acc_out, 31);
      step();
      chk("m_fetch_busy", 32'(busy), 32'd0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!busy) break;
         n = n + 1;
      end
      chk("m_busy_run", n, 7);
      chk("m_acc", acc_out, 8'hC1);
      chk("m_flags", {flag_carry, flag_zero}, 2'b10);

      // HALT, resume, resume ignored during ADD
      load(8'hC9, 8'hE0, 8'h01, 8'h00);
      do_reset();
      next_wb("h0"); chk("h0_acc", acc_out, 9);
      repeat (3) step();
      chk("h_halted", {halted, state_out}, {1'b1, 3'd4});
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (pc_ena || acc_out != 8'd9 || !halted) bad = bad + 1;
      end
      chk("h_hold", bad, 0);
      resume = 1'b1;
      step();
      resume = 1'b0;
      chk("h_resume", {pc_ena, halted}, 2'b10);
      chk("h_acc", {acc_out, flag_zero, flag_carry}, {8'd9, 2'b00});
      n = cyc;
      step();
      resume = 1'b1;
      step();
      resume = 1'b0;
      next_wb("h2");
      chk("h2_cyc", cyc - n, 3);
      chk("h2_acc", {acc_out, halted}, {8'd10, 1'b0});

      // ena freeze mid-MULT: LDI 6, MUL 7
      load(8'hC6, 8'h47, 8'h00, 8'h00);
      do_reset();
      next_wb("f0"); chk("f0_acc", acc_out, 6);
      repeat (4) step();
      chk("f_mult", 32'(state_out), 32'd2);
      ena = 1'b0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (state_out != 3'd2 || pc_ena) bad = bad + 1;
      end
      chk("f_frozen", bad, 0);
      ena = 1'b1;
      next_wb("f1");
      chk("f1_cyc", cyc, 14);
      chk("f1_acc", acc_out, 42);

      chk("no_double_pc_ena", dbl, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_exec.md
Name: instr_exec

Overview:
Instruction decode/execute stage that sits directly downstream of the mode-1 program counter + ROM. It samples the 8-bit instruction (opcode [7:5], operand [4:0]), executes it against an 8-bit accumulator (single-cycle ALU ops, multi-cycle shift-add MUL), and returns a one-cycle advance strobe that drives the PC's ena. This is the CPU core's mode-1 sequencer; accumulator, flags and state are exported as debug ports.

Parameters:
DATA_W, 8, accumulator/result width (fixed at 8 for this design; parameter used for readability only)
OPND_W, 5, operand width; also the MUL iteration count

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
ena  input  1  global enable; 0 freezes all state
instr_in  input  8  instruction from the PC/ROM stage (combinational from the current pc)
resume  input  1  single-cycle pulse that releases HALT
pc_ena  output  1  PC advance strobe, connects to PC ena
acc_out  output  8  accumulator
flag_zero  output  1  last result == 0
flag_carry  output  1  carry/borrow/overflow of last op
busy  output  1  state != FETCH
halted  output  1  state == HALT
state_out  output  3  FSM state encoding (debug)
ir_out  output  8  latched instruction register (debug)

Behaviour:
- Reset (reset=0, async): acc, ir, flags, MUL datapath = 0; state = FETCH; all outputs 0. Reset mid-operation aborts the instruction with no partial writeback.
- ena=0: no state or register changes; pc_ena=0. Everything resumes exactly where it stopped when ena returns to 1.
- States/encoding: FETCH=0, EXEC=1, MULT=2, WB=3, HALT=4.
- FETCH: ir <= instr_in; go to EXEC.
- EXEC: decode ir[7:5]. Operand is zero-extended to 8 bits.
  - 000 ADD: acc <= acc+op; carry = bit 8.
  - 001 SUB: acc <= acc-op (mod 256); carry = borrow (acc < op).
  - 010 MUL: load multiplicand = acc, multiplier = op, product = 0, count = 0; go to MULT.
  - 011 AND, 100 OR, 101 XOR: bitwise with op; carry = 0.
  - 110 LDI: acc <= op; carry = 0.
  - 111 HALT: go to HALT; acc and flags unchanged.
  - All non-MUL, non-HALT ops go to WB. zero = (new acc == 0) for every op that writes acc.
  - 0x00 (ADD 0) is the NOP: acc unchanged, carry = 0, zero recomputed.
- MULT: one multiplier bit per cycle, LSB first. If the bit is set, product += multiplicand << count (13-bit product). Exactly OPND_W=5 cycles. On the last cycle: acc <= product[7:0], carry = |product[12:8], zero = (product[7:0] == 0); go to WB.
- HALT: hold until resume=1 (with ena=1), then go to WB. resume in any other state is ignored.
- WB: pc_ena=1 for exactly this cycle (decoded from the state register, glitch-free); go to FETCH. The PC updates on the same edge, so the next FETCH sees the new instruction.
- Latency: ALU/LDI/NOP = 3 cycles per instruction (FETCH, EXEC, WB). MUL = 8 cycles (FETCH, EXEC, 5×MULT, WB). HALT = 3 cycles + wait.
- pc_ena is never high in two consecutive cycles. Exactly one pulse per retired instruction.
- Arithmetic is modulo 256; PC wrap-around is the upstream stage's concern and is transparent here.

Test Plan:
- Reset: assert reset=0 during the 3rd MULT cycle -> acc=0, flags=0, state_out=0, pc_ena=0 immediately (async). After release, the first FETCH occurs on the next edge.
- Program loop with the PC stage (ADD 3, SUB 2, MUL 5, NOP = 0x03, 0x22, 0x45, 0x00) -> acc after each WB: 3, 1, 5, 5. pc_ena pulses at cycles 2, 5, 13, 16. Second loop gives 8, 6, 30, 30.
- SUB borrow: LDI 2 (0xC2), SUB 3 (0x23) -> acc=0xFF, flag_carry=1, flag_zero=0. Then AND 0 (0x60) -> acc=0, zero=1, carry=0.
- MUL overflow: LDI 31 (0xDF), MUL 31 (0x5F) -> acc=0xC1 (961 mod 256), carry=1; busy stays high 7 consecutive cycles for the MUL.
- HALT: instr 0xE0 -> halted=1, pc_ena=0 for 20 cycles, acc unchanged. A resume pulse gives pc_ena=1 on the following cycle, then halted=0. A resume pulse during an ADD has no effect.
- ena freeze: drop ena for 4 cycles mid-MULT (LDI 6, MUL 7) -> state_out held at 2, no pc_ena. After ena returns, acc=42 and the total active cycle count equals the unfrozen case.
